game_over_ctl: RTL
==================

// Module: game_over_ctl
// PURPOSE
// - Game referee: starts a round, counts down round time per video frame, detects Tom catching Jerry,
//   and drives gameover[1:0] into the gameover overlay stage, which latches it and paints the banner.
// - Sits in game logic and runs on the pixel clock. Frame timing comes from the VGA timing vsync.
// PARAMETERS
// - GAME_SECONDS   default 60  round length in seconds. Range 1..127.
// - FRAMES_PER_SEC default 60  frame ticks per second.
// - CATCH_FRAMES   default 3   consecutive overlapping frames needed to confirm a catch. Range 1..15.
// - CHAR_W         default 32  sprite width in pixels, used for the overlap test.
// - CHAR_H         default 32  sprite height in pixels, used for the overlap test.
// PORTS
// - clk        in   1   pixel clock
// - rst        in   1   reset, asynchronous, active-high
// - start      in   1   one-cycle pulse: begin or restart a round
// - vsync      in   1   vsync from VGA timing; a rising edge marks one frame
// - tom_x      in   12  Tom sprite top-left x
// - tom_y      in   12  Tom sprite top-left y
// - jerry_x    in   12  Jerry sprite top-left x
// - jerry_y    in   12  Jerry sprite top-left y
// - gameover   out  2   00 = none, 01 = Tom wins (catch), 10 = Jerry wins (timeout); 11 never driven
// - running    out  1   high while state == RUN
// - time_left  out  7   seconds remaining
// BEHAVIOUR
// - Reset (async, all registers) values:
//   - state = IDLE, gameover = 00, running = 0
//   - time_left = GAME_SECONDS, frame counter = 0, catch counter = 0, vsync_d = 0
// - Frame tick: vsync_d registers vsync. tick = vsync & ~vsync_d, so tick is one cycle wide and occurs
//   on the first cycle vsync is seen high.
// - FSM states: IDLE, RUN, OVER.
//   - IDLE -> RUN on start. Timer reloads to GAME_SECONDS; frame and catch counters clear.
//   - RUN -> OVER on catch or timeout, evaluated only in a tick cycle. gameover is registered and
//     valid on the next clock edge, so latency is 1 cycle after the tick cycle.
//   - OVER holds gameover stable. start in OVER -> RUN with a full reload, and gameover = 00
//     on the same edge.
//   - start in RUN restarts the round: reload and stay in RUN.
// - Overlap test, in RUN on tick only. Positions are sampled in that cycle.
//   - dx = tom_x - jerry_x and dy = tom_y - jerry_y, each 13-bit signed.
//   - overlap = (|dx| < CHAR_W) && (|dy| < CHAR_H). Touching edges (|dx| == CHAR_W) do not overlap.
// - Catch counter (4 bits):
//   - overlap tick: +1, saturating at CATCH_FRAMES.
//   - non-overlap tick: cleared to 0.
//   - catch = (counter + 1 == CATCH_FRAMES) on an overlap tick.
// - Timer:
//   - The frame counter counts ticks 0..FRAMES_PER_SEC-1. On wrap, time_left decrements.
//   - timeout = wrap && time_left == 1. time_left reaches 0 and holds there in OVER.
// - Simultaneous catch and timeout on the same tick: gameover = 01 (catch has priority).
// - Only ticks that occur in RUN count. Ticks in IDLE and OVER are ignored.
// - Reset asserted mid-round: immediate return to the reset values. No gameover is emitted.
// CONFIGURATION
// - Macro GAMEOVER_PAUSE_EN.
// - Defined: adds input port pause (1 bit).
//   - While pause = 1 in RUN: ticks do not advance the frame, timer or catch counters, and do not
//     evaluate overlap.
//   - start still works. running stays 1.
// - Undefined: no pause port, and every RUN tick counts.
// TESTING
// - Reset and idle:
//   - Stimulus: assert rst, release, toggle vsync 10 frames.
//   - Required: gameover = 00, running = 0, time_left = 60 throughout.
// - Timeout, with GAME_SECONDS = 2 and FRAMES_PER_SEC = 4:
//   - Stimulus: start, sprites far apart (tom = (0,0), jerry = (200,200)).
//   - Required: time_left = 1 after 4 ticks; gameover = 10 one cycle after the 8th tick; time_left = 0.
// - Catch:
//   - Stimulus: start, tom = (100,100), jerry = (120,110) for 3 ticks.
//   - Required: gameover = 01 one cycle after the 3rd tick; running = 0.
// - Catch reset by a gap:
//   - Stimulus: overlap 2 ticks, then jerry = (132,100) (|dx| = 32) for 1 tick, then overlap 2 ticks.
//   - Required: gameover stays 00.
// - Tie:
//   - Stimulus: 3rd overlap tick coincides with the final timer wrap.
//   - Required: gameover = 01.
// - Restart and async reset:
//   - Stimulus: start in OVER, then rst pulsed mid-RUN, not aligned to clk.
//   - Required: the start clears gameover to 00 and reloads time_left = GAME_SECONDS; the rst returns
//     state to IDLE immediately.
// - With GAMEOVER_PAUSE_EN defined:
//   - Stimulus: pause = 1 for 20 ticks in RUN.
//   - Required: time_left is unchanged.

Source files
------------

// File: rtl/game_over_ctl.sv
// Round referee: counts down round time per vsync frame, confirms a Tom/Jerry catch, and reports the winner.
// Optional GAMEOVER_PAUSE_EN adds a pause input that freezes all round progress while in RUN.
module game_over_ctl #(
  parameter int unsigned GAME_SECONDS   = 60,
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned CATCH_FRAMES   = 3,
  parameter int unsigned CHAR_W         = 32,
  parameter int unsigned CHAR_H         = 32
) (
  input  logic        clk,
  input  logic        rst,
`ifdef GAMEOVER_PAUSE_EN
  input  logic        pause,
`endif
  input  logic        start,
  input  logic        vsync,
  input  logic [11:0] tom_x,
  input  logic [11:0] tom_y,
  input  logic [11:0] jerry_x,
  input  logic [11:0] jerry_y,
  output logic [1:0]  gameover,
  output logic        running,
  output logic [6:0]  time_left
);

  localparam int unsigned FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]      TL_INIT = 7'(GAME_SECONDS);
  localparam logic [4:0]      CF      = 5'(CATCH_FRAMES);
  localparam logic [12:0]     CW      = 13'(CHAR_W);
  localparam logic [12:0]     CH      = 13'(CHAR_H);

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t          state_q, state_nxt;
  logic [1:0]      gameover_q, gameover_nxt;
  logic [6:0]      time_left_q, time_left_nxt;
  logic [FC_W-1:0] frame_q, frame_nxt;
  logic [3:0]      catch_q, catch_nxt;
  logic            vsync_d;

  logic            tick;
  logic            count_en;
  logic            paused;
  logic [12:0]     dx, dy, dx_abs, dy_abs;
  logic            overlap;
  logic [4:0]      catch_sum;
  logic            catch_hit;
  logic            wrap;
  logic            timeout;

  assign tick = vsync & ~vsync_d;

`ifdef GAMEOVER_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign count_en = tick && (state_q == RUN) && !paused;

  // Zero-extend to 13 bits so the difference of two 12-bit positions is exact two's complement.
  assign dx     = {1'b0, tom_x} - {1'b0, jerry_x};
  assign dy     = {1'b0, tom_y} - {1'b0, jerry_y};
  assign dx_abs = dx[12] ? (~dx + 13'd1) : dx;
  assign dy_abs = dy[12] ? (~dy + 13'd1) : dy;
  assign overlap = (dx_abs < CW) && (dy_abs < CH);

  assign catch_sum = {1'b0, catch_q} + 5'd1;
  assign catch_hit = overlap && (catch_sum == CF);

  assign wrap    = (frame_q == FC_LAST);
  assign timeout = wrap && (time_left_q == 7'd1);

  always_comb begin
    state_nxt     = state_q;
    gameover_nxt  = gameover_q;
    time_left_nxt = time_left_q;
    frame_nxt     = frame_q;
    catch_nxt     = catch_q;

    if (start) begin
      state_nxt     = RUN;
      gameover_nxt  = 2'b00;
      time_left_nxt = TL_INIT;
      frame_nxt     = '0;
      catch_nxt     = '0;
    end else if (count_en) begin
      if (wrap) begin
        frame_nxt     = '0;
        time_left_nxt = time_left_q - 7'd1;
      end else begin
        frame_nxt = frame_q + 1'b1;
      end

      if (!overlap)
        catch_nxt = '0;
      else if (catch_sum >= CF)
        catch_nxt = CF[3:0];
      else
        catch_nxt = catch_sum[3:0];

      // Catch wins a tie with the final timer wrap.
      if (catch_hit) begin
        state_nxt    = OVER;
        gameover_nxt = 2'b01;
      end else if (timeout) begin
        state_nxt    = OVER;
        gameover_nxt = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gameover_q  <= 2'b00;
      time_left_q <= TL_INIT;
      frame_q     <= '0;
      catch_q     <= '0;
      vsync_d     <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      gameover_q  <= gameover_nxt;
      time_left_q <= time_left_nxt;
      frame_q     <= frame_nxt;
      catch_q     <= catch_nxt;
      vsync_d     <= vsync;
    end
  end

  assign gameover  = gameover_q;
  assign running   = (state_q == RUN);
  assign time_left = time_left_q;

endmodule
